// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Contents:
//   arb_state_e    - arbiter FSM state (idle / burst in progress)
//   *_DEF          - default parameter values and derived widths
//   idx_w / cnt_w  - width helpers for requester index and beat counter
//   wrap_inc       - increment with explicit wrap at n-1 -> 0
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    localparam int unsigned NUM_REQ_DEF   = 4;
    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned MAX_BURST_DEF = 4;
    localparam int unsigned IDX_W_DEF     = $clog2(NUM_REQ_DEF);
    localparam int unsigned CNT_W_DEF     = $clog2(MAX_BURST_DEF + 1);

    function automatic int unsigned idx_w(input int unsigned num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned max_burst);
        return $clog2(max_burst + 1);
    endfunction

    // Works for any n, not only powers of two.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v >= n - 1) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_i    - request vector
//   start_i  - highest-priority index for this search
//   found_o  - at least one request is set
//   idx_o    - first requesting index at or after start_i, modulo NUM_REQ
module rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] start_i,
    output logic                       found_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    always_comb begin
        // NOTE: every output gets a default before the search so that no
        // path leaves it unassigned; otherwise a latch would be inferred.
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            automatic int unsigned pos = 32'(start_i) + 32'(k);
            automatic logic [IDX_W-1:0] p;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            p = IDX_W'(pos);
            if (!found_o && req_i[p]) begin
                found_o = 1'b1;
                idx_o   = p;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with burst lock for the async FIFO.
// A granted requester keeps the port until it flags last_i or MAX_BURST
// beats are accepted. Data and strobe pass through combinationally.
// Ports:
//   wclk, wrst   - write clock, synchronous active-high reset
//   req_i        - per-requester beat valid
//   data_i       - per-requester data, slice i = [i*DATA_W +: DATA_W]
//   last_i       - per-requester last-beat marker (qualified by req_i)
//   wfull_i      - FIFO full flag; blocks acceptance
//   gnt_o        - one-hot grant, zero when nobody is granted
//   wincr_o      - FIFO write strobe (beat accepted this cycle)
//   wdata_o      - data of the granted requester, zero when no grant
//   busy_o       - high while a burst holds the port
//   owner_o      - current or most recent granted index
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                        wclk,
    input  logic                        wrst,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*DATA_W-1:0]   data_i,
    input  logic [NUM_REQ-1:0]          last_i,
    input  logic                        wfull_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic                        wincr_o,
    output logic [DATA_W-1:0]           wdata_o,
    output logic                        busy_o,
    output logic [$clog2(NUM_REQ)-1:0]  owner_o
);

    localparam int unsigned IDX_W = idx_w(NUM_REQ);
    localparam int unsigned CNT_W = cnt_w(MAX_BURST);

    arb_state_e       state_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [CNT_W-1:0] beat_cnt_q;
    logic [CNT_W-1:0] beat_cnt_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             req_sel;
    logic             last_sel;
    logic             accept;
    logic             burst_end;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i   (req_i),
        .start_i (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        // In BURST the owner holds the grant even with req_i low (bubble).
        gnt_idx  = (state_q == ARB_BURST) ? owner_q : pick_idx;
        gnt_vld  = !wrst && ((state_q == ARB_BURST) || pick_found);
        gnt_o    = '0;
        wdata_o  = '0;
        req_sel  = 1'b0;
        last_sel = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt_vld && (gnt_idx == IDX_W'(i))) begin
                gnt_o[i] = 1'b1;
                wdata_o  = data_i[i*DATA_W +: DATA_W];
                req_sel  = req_i[i];
                last_sel = last_i[i];
            end
        end
        accept     = req_sel && !wfull_i;
        wincr_o    = accept;
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
        // In IDLE beat_cnt_q is 0, so this also covers MAX_BURST == 1.
        burst_end  = last_sel || (beat_cnt_d == CNT_W'(MAX_BURST));
    end

    assign busy_o  = !wrst && (state_q == ARB_BURST);
    assign owner_o = wrst ? '0 : owner_q;

    always_ff @(posedge wclk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the values from before this edge.
        if (wrst) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    // wfull_i stall: nothing changes, re-arbitrate next cycle.
                    if (accept) begin
                        owner_q <= gnt_idx;
                        if (burst_end) begin
                            rr_ptr_q <= IDX_W'(wrap_inc(32'(gnt_idx), NUM_REQ));
                        end else begin
                            state_q    <= ARB_BURST;
                            beat_cnt_q <= beat_cnt_d;
                        end
                    end
                end
                ARB_BURST: begin
                    if (accept) begin
                        if (burst_end) begin
                            state_q    <= ARB_IDLE;
                            beat_cnt_q <= '0;
                            rr_ptr_q   <= IDX_W'(wrap_inc(32'(owner_q), NUM_REQ));
                        end else begin
                            beat_cnt_q <= beat_cnt_d;
                        end
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: stimulus pushes expected writes,
// a negedge monitor pops and compares whenever wincr_o is high.
module tb_fifo_wr_arbiter;

    logic        wclk = 1'b0;
    logic        wrst = 1'b1;
    logic [3:0]  req_i = '0;
    logic [3:0]  last_i = '0;
    logic        wfull_i = 1'b0;
    logic [31:0] data_i = '0;

    logic [3:0]  gnt_o;
    logic        wincr_o;
    logic [7:0]  wdata_o;
    logic        busy_o;
    logic [1:0]  owner_o;

    logic [3:0]  gnt1;
    logic        wincr1;
    logic [7:0]  wdata1;
    logic        busy1;
    logic [1:0]  owner1;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) u_dut (
        .wclk    (wclk),
        .wrst    (wrst),
        .req_i   (req_i),
        .data_i  (data_i),
        .last_i  (last_i),
        .wfull_i (wfull_i),
        .gnt_o   (gnt_o),
        .wincr_o (wincr_o),
        .wdata_o (wdata_o),
        .busy_o  (busy_o),
        .owner_o (owner_o)
    );

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(1)) u_dut_mb1 (
        .wclk    (wclk),
        .wrst    (wrst),
        .req_i   (req_i),
        .data_i  (data_i),
        .last_i  (last_i),
        .wfull_i (wfull_i),
        .gnt_o   (gnt1),
        .wincr_o (wincr1),
        .wdata_o (wdata1),
        .busy_o  (busy1),
        .owner_o (owner1)
    );

    always #5 wclk = ~wclk;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] data;
    } wr_t;

    wr_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  wr_count = 0;
    int  cyc_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t cyc %0d: got 0x%0h expected 0x%0h", name, $time, cyc_cnt, act, exp);
        end
    endtask

    function automatic logic [7:0] slice_val(input int i, input int c);
        return 8'((i << 4) | (c & 15));
    endfunction

    function automatic int oh2idx(input logic [3:0] oh);
        int r = 0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = i;
        return r;
    endfunction

    task automatic drive_data();
        for (int i = 0; i < 4; i++) data_i[i*8 +: 8] = slice_val(i, cyc_cnt);
    endtask

    // Apply inputs, queue the expected write, check grant/strobe/busy.
    task automatic cyc_set(input logic [3:0] req, input logic [3:0] last, input logic full,
                           input logic wr, input logic [3:0] exp_gnt, input logic exp_busy);
        req_i   = req;
        last_i  = last;
        wfull_i = full;
        drive_data();
        if (wr) sb_q.push_back('{gnt: exp_gnt, data: slice_val(oh2idx(exp_gnt), cyc_cnt)});
        #2;
        check("gnt", 32'(gnt_o), 32'(exp_gnt));
        check("wincr", 32'(wincr_o), 32'(wr));
        check("busy", 32'(busy_o), 32'(exp_busy));
    endtask

    task automatic cyc_end();
        @(posedge wclk);
        #1;
        cyc_cnt++;
    endtask

    task automatic cyc(input logic [3:0] req, input logic [3:0] last, input logic full,
                       input logic wr, input logic [3:0] exp_gnt, input logic exp_busy);
        cyc_set(req, last, full, wr, exp_gnt, exp_busy);
        cyc_end();
    endtask

    task automatic do_reset(input logic [3:0] req, input int n);
        wrst    = 1'b1;
        req_i   = req;
        last_i  = '0;
        wfull_i = 1'b0;
        for (int k = 0; k < n; k++) begin
            drive_data();
            #2;
            check("rst_gnt", 32'(gnt_o), 32'd0);
            check("rst_wincr", 32'(wincr_o), 32'd0);
            check("rst_busy", 32'(busy_o), 32'd0);
            check("rst_owner", 32'(owner_o), 32'd0);
            check("rst_gnt_mb1", 32'(gnt1), 32'd0);
            cyc_end();
        end
        wrst = 1'b0;
    endtask

    // Scoreboard monitor: every write strobe must match the queue head.
    always @(negedge wclk) begin
        if (wincr_o) begin
            wr_count++;
            if (sb_q.size() == 0) begin
                check("sb_pop", 32'(sb_q.size()), 32'd1);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check("wr_gnt", 32'(gnt_o), 32'(e.gnt));
                check("wr_data", 32'(wdata_o), 32'(e.data));
            end
        end
    end

    initial begin
        int w0;

        // Reset held 3 cycles with all requests active.
        do_reset(4'b1111, 3);

        // Rotation on the MAX_BURST=1 instance; main instance bursts on 0.
        for (int k = 0; k < 5; k++) begin
            cyc_set(4'b1111, 4'b0000, 1'b0, 1'b1,
                    (k < 4) ? 4'b0001 : 4'b0010, (k >= 1 && k <= 3));
            check("rot_gnt", 32'(gnt1), 32'(4'b0001 << (k % 4)));
            check("rot_wincr", 32'(wincr1), 32'd1);
            check("rot_wdata", 32'(wdata1), 32'(slice_val(k % 4, cyc_cnt)));
            cyc_end();
        end
        do_reset(4'b0000, 1);

        // Burst lock: req 0 capped at 4 beats, then 2 gets the port.
        cyc(4'b0101, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b0);
        repeat (3) cyc(4'b0101, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b1);
        cyc(4'b0101, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0);
        // req 0 with last on its second beat.
        cyc(4'b0101, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b0);
        cyc(4'b0101, 4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1);
        cyc(4'b0101, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);

        // Full stall at beat_cnt=2; all 4 beats still written.
        w0 = wr_count;
        cyc(4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b0);
        check("owner_after_grant", 32'(owner_o), 32'd0);
        cyc(4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b1);
        repeat (3) cyc(4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0001, 1'b1);
        cyc(4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b1);
        cyc(4'b0001, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        check("stall_writes", 32'(wr_count - w0), 32'd4);

        // Full while idle: grant shown, no write, pointer kept.
        cyc(4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0010, 1'b0);
        cyc(4'b0011, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b0);

        // Owner bubble: owner 2 drops req while req 1 waits.
        cyc(4'b0100, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b0);
        cyc(4'b0110, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1);
        repeat (2) cyc(4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1);
        cyc(4'b0110, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1);
        cyc(4'b0110, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1);
        cyc(4'b0010, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b0);

        // Mid-burst reset from index 3; restart searches from 0.
        cyc(4'b1000, 4'b0000, 1'b0, 1'b1, 4'b1000, 1'b0);
        check("owner_idx3", 32'(owner_o), 32'd3);
        cyc(4'b1000, 4'b0000, 1'b0, 1'b1, 4'b1000, 1'b1);
        do_reset(4'b1001, 1);
        cyc(4'b1001, 4'b0001, 1'b0, 1'b1, 4'b0001, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
